maze_player_mover: RTL
======================

Name: maze_player_mover

Overview:
- Consumes the per-cell movement constraint arrays produced by the maze world stage.
- Moves a single player token one cell per accepted move request.
- Rejects moves blocked by a wall, a constraint bit or the maze boundary.
- Rate-limits movement with a cooldown counter and detects arrival at the goal cell.
- Feeds player position and move/win status to the draw and game-control logic downstream.

Parameters:
- size_y, 20, maze rows.
- size_x, 40, maze columns.
- START_X, 0, column of the start cell.
- START_Y, 0, row of the start cell.
- GOAL_X, 39, column of the goal cell.
- GOAL_Y, 19, row of the goal cell.
- COOLDOWN, 4, idle cycles enforced after each successful move (>=1).
- XW/YW, $clog2(size_x)/$clog2(size_y), derived position widths; not for override.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  synchronous active-low reset.
- restart  in  1  synchronous return to start; clears win and step state.
- move_req  in  1  move request strobe.
- dir  in  4  one-hot {up,down,left,right}, sampled with move_req.
- up_constraint  in  [0:size_x-1] x [size_y-1:0]  1 = move up blocked from cell.
- down_constraint  in  same  1 = move down blocked.
- left_constraint  in  same  1 = move left blocked.
- right_constraint  in  same  1 = move right blocked.
- pos_x  out  XW  current column.
- pos_y  out  YW  current row.
- busy  out  1  high outside IDLE.
- moved  out  1  one-cycle pulse on a successful step.
- blocked  out  1  one-cycle pulse on a rejected request.
- win  out  1  level, high in WON.

Behaviour:
- Indexing: constraint[y][x]; x=0 leftmost, y=0 top; up decrements y, down increments y.
- Reset (Reset_n=0 at posedge):
  - pos=(START_X,START_Y); state IDLE.
  - busy, moved, blocked and win all 0; cooldown counter 0.
  - Reset overrides every state, including mid-cooldown.
- restart: same effect as reset, except when reset is also asserted. Has priority over move_req.
- States:
  - IDLE: move_req=1 latches dir; go to CHECK. move_req with dir=0 is ignored and the block stays in IDLE.
  - CHECK: priority decode when more than one dir bit is set: up>down>left>right.
    - Blocked if the constraint bit at the current position for that direction is 1, or the target cell is off-grid (y=0 up, y=size_y-1 down, x=0 left, x=size_x-1 right).
    - Blocked: pulse blocked next cycle; return to IDLE; no cooldown.
    - Clear: go to MOVE.
  - MOVE: pos updates on this edge; moved=1 for exactly this cycle.
    - New pos == (GOAL_X,GOAL_Y): go to WON.
    - Otherwise: load cooldown=COOLDOWN; go to COOL.
  - COOL: decrement each cycle; at 0 go to IDLE. move_req is ignored (dropped, not queued).
  - WON: win=1; pos holds; all move_req ignored; leave only via restart/reset.
- Latency: request at edge N → pos valid and moved high after edge N+2. The next request is accepted no earlier than edge N+3+COOLDOWN.
- busy=1 in CHECK, MOVE, COOL and WON.
- Constraint inputs are combinational from upstream and must be stable while busy. They are sampled only in CHECK.
- Position arithmetic is unsigned at XW/YW widths. The boundary check precedes increment/decrement, so wrap can never occur.

Optional Feature:
- Macro: MAZE_STEP_COUNT_EN.
- Defined:
  - Adds output step_count (16 bits), incremented on each moved pulse and saturating at 16'hFFFF.
  - Adds output bump_count (8 bits), incremented on each blocked pulse and saturating at 8'hFF.
  - Both clear on reset and restart.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset then open corridor: all constraints 0, request right at pos (0,0) → moved after 2 edges; pos=(1,0); busy for 2+COOLDOWN cycles.
- Wall: right_constraint[0][0]=1, request right → blocked pulse; pos stays (0,0); back in IDLE next cycle; no cooldown.
- Boundary: at (0,0) request up and then left with all constraints 0 → two blocked pulses; pos unchanged.
- Priority and cooldown drop: dir=4'b1011 at (5,5) → moves up to (5,4). A request during COOL is dropped, and pos changes only once.
- Win: place at (38,19), request right → pos=(39,19); win=1. Further requests leave pos unchanged. restart → pos=(0,0), win=0.
- Reset mid-operation: assert Reset_n=0 during COOL and WON → next cycle pos=start and all outputs 0. With MAZE_STEP_COUNT_EN, step_count returns to 0 after 3 moves plus reset.

Source files
------------

// File: rtl/maze_player_mover.sv
`default_nettype none
// ============================================================================
//  Module      : maze_player_mover
//  Description : Steps one player token through the maze using per-cell wall
//                constraints. Optional step/bump counters: MAZE_STEP_COUNT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module maze_player_mover #(
  parameter int size_y   = 20,
  parameter int size_x   = 40,
  parameter int START_X  = 0,
  parameter int START_Y  = 0,
  parameter int GOAL_X   = 39,
  parameter int GOAL_Y   = 19,
  parameter int COOLDOWN = 4
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        restart,
  input  logic                        move_req,
  input  logic [3:0]                  dir,
  input  logic [0:size_x-1]           up_constraint    [size_y-1:0],
  input  logic [0:size_x-1]           down_constraint  [size_y-1:0],
  input  logic [0:size_x-1]           left_constraint  [size_y-1:0],
  input  logic [0:size_x-1]           right_constraint [size_y-1:0],
  output logic [$clog2(size_x)-1:0]   pos_x,
  output logic [$clog2(size_y)-1:0]   pos_y,
  output logic                        busy,
  output logic                        moved,
  output logic                        blocked,
  output logic                        win
`ifdef MAZE_STEP_COUNT_EN
  ,
  output logic [15:0]                 step_count,
  output logic [7:0]                  bump_count
`endif
);

  localparam int c_XW = $clog2(size_x);
  localparam int c_YW = $clog2(size_y);
  localparam int c_CW = $clog2(COOLDOWN + 1);

  localparam logic [c_XW-1:0] c_START_X = c_XW'(START_X);
  localparam logic [c_YW-1:0] c_START_Y = c_YW'(START_Y);
  localparam logic [c_XW-1:0] c_GOAL_X  = c_XW'(GOAL_X);
  localparam logic [c_YW-1:0] c_GOAL_Y  = c_YW'(GOAL_Y);
  localparam logic [c_XW-1:0] c_LAST_X  = c_XW'(size_x - 1);
  localparam logic [c_YW-1:0] c_LAST_Y  = c_YW'(size_y - 1);
  localparam logic [c_CW-1:0] c_COOL    = c_CW'(COOLDOWN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_MOVE  = 3'd2,
    S_COOL  = 3'd3,
    S_WON   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_dir;
  logic [c_XW-1:0]   r_pos_x;
  logic [c_YW-1:0]   r_pos_y;
  logic [c_CW-1:0]   r_cool;
  logic [c_CW-1:0]   w_cool_next;
  logic              r_moved;
  logic              r_blocked;

  logic              w_clear;
  logic              w_load_dir;
  logic              w_do_move;
  logic              w_do_block;

  logic              w_go_up;
  logic              w_go_down;
  logic              w_go_left;
  logic              w_go_right;
  logic              w_at_edge;
  logic              w_wall;
  logic              w_blk;
  logic [c_XW-1:0]   w_tgt_x;
  logic [c_YW-1:0]   w_tgt_y;
  logic              w_tgt_goal;

  assign w_clear = !Reset_n || restart;

  // One-hot resolution of the latched request: up > down > left > right.
  assign w_go_up    = r_dir[3];
  assign w_go_down  = !r_dir[3] && r_dir[2];
  assign w_go_left  = !r_dir[3] && !r_dir[2] && r_dir[1];
  assign w_go_right = !r_dir[3] && !r_dir[2] && !r_dir[1] && r_dir[0];

  always_comb begin
    w_at_edge = 1'b0;
    w_wall    = 1'b0;
    w_tgt_x   = r_pos_x;
    w_tgt_y   = r_pos_y;
    if (w_go_up) begin
      w_at_edge = (r_pos_y == '0);
      w_wall    = up_constraint[r_pos_y][r_pos_x];
      w_tgt_y   = r_pos_y - c_YW'(1);
    end else if (w_go_down) begin
      w_at_edge = (r_pos_y == c_LAST_Y);
      w_wall    = down_constraint[r_pos_y][r_pos_x];
      w_tgt_y   = r_pos_y + c_YW'(1);
    end else if (w_go_left) begin
      w_at_edge = (r_pos_x == '0);
      w_wall    = left_constraint[r_pos_y][r_pos_x];
      w_tgt_x   = r_pos_x - c_XW'(1);
    end else if (w_go_right) begin
      w_at_edge = (r_pos_x == c_LAST_X);
      w_wall    = right_constraint[r_pos_y][r_pos_x];
      w_tgt_x   = r_pos_x + c_XW'(1);
    end
  end

  // Target arithmetic may wrap, but a wrapped target is always rejected here.
  assign w_blk      = w_at_edge || w_wall;
  assign w_tgt_goal = (w_tgt_x == c_GOAL_X) && (w_tgt_y == c_GOAL_Y);

  always_comb begin
    w_state_next = r_state;
    w_cool_next  = r_cool;
    w_load_dir   = 1'b0;
    w_do_move    = 1'b0;
    w_do_block   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (move_req && (dir != 4'd0)) begin
          w_load_dir   = 1'b1;
          w_state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_blk) begin
          w_do_block   = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_MOVE;
        end
      end
      S_MOVE: begin
        w_do_move = 1'b1;
        if (w_tgt_goal) begin
          w_state_next = S_WON;
        end else begin
          w_cool_next  = c_COOL;
          w_state_next = S_COOL;
        end
      end
      S_COOL: begin
        if (r_cool <= c_CW'(1)) begin
          w_cool_next  = '0;
          w_state_next = S_IDLE;
        end else begin
          w_cool_next  = r_cool - c_CW'(1);
        end
      end
      S_WON: begin
        w_state_next = S_WON;
      end
      default: begin
        w_cool_next  = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (w_clear) begin
      r_state   <= S_IDLE;
      r_dir     <= 4'd0;
      r_pos_x   <= c_START_X;
      r_pos_y   <= c_START_Y;
      r_cool    <= '0;
      r_moved   <= 1'b0;
      r_blocked <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cool    <= w_cool_next;
      r_moved   <= w_do_move;
      r_blocked <= w_do_block;
      if (w_load_dir) begin
        r_dir <= dir;
      end
      if (w_do_move) begin
        r_pos_x <= w_tgt_x;
        r_pos_y <= w_tgt_y;
      end
    end
  end

`ifdef MAZE_STEP_COUNT_EN
  logic [15:0] r_step_count;
  logic [7:0]  r_bump_count;

  // Counters follow the same edge that raises the moved/blocked pulses.
  always_ff @(posedge Clk) begin
    if (w_clear) begin
      r_step_count <= 16'd0;
      r_bump_count <= 8'd0;
    end else begin
      if (w_do_move && (r_step_count != 16'hFFFF)) begin
        r_step_count <= r_step_count + 16'd1;
      end
      if (w_do_block && (r_bump_count != 8'hFF)) begin
        r_bump_count <= r_bump_count + 8'd1;
      end
    end
  end

  assign step_count = r_step_count;
  assign bump_count = r_bump_count;
`endif

  assign pos_x   = r_pos_x;
  assign pos_y   = r_pos_y;
  assign busy    = (r_state != S_IDLE);
  assign moved   = r_moved;
  assign blocked = r_blocked;
  assign win     = (r_state == S_WON);

endmodule
`default_nettype wire
